// File: rtl/hazard_sequencer_pkg.sv
// Shared encodings and helpers for the pipeline hazard sequencer.
package hazard_sequencer_pkg;

    // Sequencer states: normal issue, or frozen waiting on data memory.
    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // Forwarding select encodings (match the datapath operand muxes).
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Controller encodings this block decodes.
    localparam logic [1:0] RES_SRC_LOAD    = 2'b01;
    localparam logic [1:0] PCSRC_PC_PLUS_4 = 2'b00;

    // Per-stage hold / bubble controls.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctrl_t;

    // Operand bypass select: M-stage producer beats W-stage producer, x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard sequencer for the 5-stage core: bypass selects, load-use stalls,
// redirect flushes, data-memory wait freeze, perf counters, timeout flag.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic [1:0]       PCSrcE,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // Wide enough to hold MEM_TIMEOUT-1 even when MEM_TIMEOUT is 1.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state, state_nxt;
    hz_ctrl_t          run_ctrl, ctrl;
    logic              redirect, load_use, redirect_flush;
    logic [WAIT_W-1:0] wait_cnt;

    assign redirect = (PCSrcE != PCSRC_PC_PLUS_4);
    assign load_use = (ResultSrcE == RES_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // Unfrozen controls: redirect outranks load-use (the loaded value is squashed anyway).
    always_comb begin
        run_ctrl = '0;
        if (redirect) begin
            run_ctrl.flush_d = 1'b1;
            run_ctrl.flush_e = 1'b1;
        end else if (load_use) begin
            run_ctrl.stall_f = 1'b1;
            run_ctrl.stall_d = 1'b1;
            run_ctrl.flush_e = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    // Next state and stage controls; a pending memory access freezes F..M and bubbles W.
    always_comb begin
        state_nxt      = state;
        ctrl           = '0;
        redirect_flush = 1'b0;
        if (rst) begin
            state_nxt    = ST_RUN;
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (MemReqM && !MemAckM) begin
                        ctrl      = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                      stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                      flush_w: 1'b1};
                        state_nxt = ST_MEM_WAIT;
                    end else begin
                        ctrl           = run_ctrl;
                        redirect_flush = redirect;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!MemAckM) begin
                        ctrl = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                 stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                 flush_w: 1'b1};
                    end else begin
                        // Ack releases the freeze this cycle; E sees its held redirect now.
                        ctrl           = run_ctrl;
                        redirect_flush = redirect;
                        state_nxt      = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // Bypass selects are state-independent but forced to regfile during reset.
    always_comb begin
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;
        if (!rst) begin
            ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
            ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
        end
    end

    assign StallF = ctrl.stall_f;
    assign StallD = ctrl.stall_d;
    assign StallE = ctrl.stall_e;
    assign StallM = ctrl.stall_m;
    assign FlushD = ctrl.flush_d;
    assign FlushE = ctrl.flush_e;
    assign FlushW = ctrl.flush_w;

    // Wait-cycle counter and sticky timeout flag; counter parks at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else if (state == ST_MEM_WAIT) begin
            if (MemAckM) begin
                wait_cnt <= '0;
            end else begin
                if (wait_cnt == WAIT_LAST)
                    MemErr <= 1'b1;
                else
                    wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.stall_f),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_flush),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus a random run
// compared against a cycle-level behavioural model.
module tb_hazard_sequencer;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE, PCSrcE;
    logic             MemReqM, MemAckM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int total = 0;
    int bad   = 0;

    // Model state.
    bit m_wait;
    int m_wcnt, m_sc, m_fc;
    bit m_err;

    always #5 clk = ~clk;

    hazard_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [10:0] obs;
    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    // Nearest producer wins; x0 is never a producer.
    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit model_frozen();
        return !rst && !MemAckM && (m_wait || MemReqM);
    endfunction

    function automatic logic [10:0] exp_comb();
        logic [10:0] e;
        e = '0;
        if (rst) return 11'b0000_0000_110;
        e[10:9] = model_fwd(Rs1E);
        e[8:7]  = model_fwd(Rs2E);
        if (model_frozen())
            e[6:0] = 7'b1111_001;
        else if (PCSrcE != 2'b00)
            e[6:0] = 7'b0000_110;
        else if (ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D))
            e[6:0] = 7'b1100_010;
        return e;
    endfunction

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic tick();
        logic [10:0] e;
        bit redir, ack, req, r;
        e     = exp_comb();
        redir = !rst && PCSrcE != 2'b00 && !model_frozen();
        ack   = MemAckM;
        req   = MemReqM;
        r     = rst;
        @(posedge clk);
        if (r) begin
            m_wait = 0; m_wcnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (e[6] && m_sc < SAT) m_sc++;
            if (redir && m_fc < SAT) m_fc++;
            if (m_wait) begin
                if (ack) begin
                    m_wait = 0; m_wcnt = 0;
                end else begin
                    if (m_wcnt == TIMEOUT - 1) m_err = 1;
                    m_wcnt++;
                end
            end else if (req && !ack) begin
                m_wait = 1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
        MemReqM = 0; MemAckM = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        RegWriteM = 1; RdM = 3; Rs1E = 3;
        #2;
        total++;
        if (obs !== 11'b0000_0000_110) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=%b", obs, 11'b0000_0000_110);
        end
        tick();
        rst = 0;
        idle_inputs();
        #2;
        total++;
        if ({MemErr, StallCount, FlushCount} !== '0 || obs !== '0) begin
            bad++; $display("FAIL reset_state err=%b sc=%0d fc=%0d ctrl=%b exp=0", MemErr, StallCount, FlushCount, obs);
        end
    endtask

    task automatic test_forward();
        do_reset();
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #2;
        total++;
        if (ForwardAE !== 2'b10) begin bad++; $display("FAIL fwd_a_mem got=%b exp=10", ForwardAE); end
        RdM = 0;
        #2;
        total++;
        if (ForwardAE !== 2'b01) begin bad++; $display("FAIL fwd_a_wb got=%b exp=01", ForwardAE); end
        Rs2E = 9; RdM = 9; RdW = 4; RegWriteW = 0;
        #2;
        total++;
        if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) begin
            bad++; $display("FAIL fwd_b_mem got=%b/%b exp=00/10", ForwardAE, ForwardBE);
        end
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #2;
        total++;
        if (obs !== 11'b0000_1100_010) begin bad++; $display("FAIL load_use got=%b exp=%b", obs, 11'b0000_1100_010); end
        tick();
        idle_inputs();
        #2;
        total++;
        if (StallCount !== 4'd1 || obs !== '0) begin
            bad++; $display("FAIL load_use_cnt sc=%0d ctrl=%b exp sc=1 ctrl=0", StallCount, obs);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 2'b01;
        #2;
        total++;
        if (obs !== 11'b0000_0000_110) begin bad++; $display("FAIL redirect got=%b exp=%b", obs, 11'b0000_0000_110); end
        tick();
        idle_inputs();
        #2;
        total++;
        if (FlushCount !== 4'd1 || StallCount !== 4'd0) begin
            bad++; $display("FAIL redirect_cnt fc=%0d sc=%0d exp fc=1 sc=0", FlushCount, StallCount);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        MemReqM = 1; MemAckM = 0;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (obs !== 11'b0000_1111_001) begin bad++; $display("FAIL mem_freeze cyc=%0d got=%b exp=%b", i, obs, 11'b0000_1111_001); end
            tick();
        end
        MemAckM = 1;
        #2;
        total++;
        if (obs !== '0) begin bad++; $display("FAIL mem_release got=%b exp=0", obs); end
        tick();
        idle_inputs();
        #2;
        total++;
        if (StallCount !== 4'd3 || obs !== '0) begin
            bad++; $display("FAIL mem_after sc=%0d ctrl=%b exp sc=3 ctrl=0", StallCount, obs);
        end
        // Redirect held in E during a wait is acted on only at release.
        do_reset();
        MemReqM = 1; MemAckM = 0; PCSrcE = 2'b10;
        tick(); tick();
        #2;
        total++;
        if (obs !== 11'b0000_1111_001) begin bad++; $display("FAIL mem_redir_hold got=%b exp=%b", obs, 11'b0000_1111_001); end
        MemAckM = 1;
        #2;
        total++;
        if (obs !== 11'b0000_0000_110) begin bad++; $display("FAIL mem_redir_rel got=%b exp=%b", obs, 11'b0000_0000_110); end
        tick();
        idle_inputs();
        #2;
        total++;
        if (FlushCount !== 4'd1) begin bad++; $display("FAIL mem_redir_cnt fc=%0d exp=1", FlushCount); end
    endtask

    task automatic test_timeout();
        do_reset();
        MemReqM = 1; MemAckM = 0;
        // One RUN cycle enters the wait, then TIMEOUT wait cycles raise the flag.
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            tick();
            #2;
            total++;
            if (MemErr !== (i == TIMEOUT + 1)) begin
                bad++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, MemErr, (i == TIMEOUT + 1));
            end
        end
        MemAckM = 1;
        tick();
        MemReqM = 0; MemAckM = 0;
        tick(); tick();
        #2;
        total++;
        if (MemErr !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", MemErr); end
    endtask

    task automatic test_rst_midwait();
        MemReqM = 1; MemAckM = 0;
        tick();
        rst = 1;
        #2;
        total++;
        if (obs !== 11'b0000_0000_110) begin bad++; $display("FAIL rst_wait_ctrl got=%b exp=%b", obs, 11'b0000_0000_110); end
        tick();
        rst = 0; MemReqM = 0;
        #2;
        total++;
        if (obs !== '0 || MemErr !== 1'b0 || StallCount !== '0 || FlushCount !== '0) begin
            bad++; $display("FAIL rst_wait_after ctrl=%b err=%b sc=%0d fc=%0d exp all 0", obs, MemErr, StallCount, FlushCount);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        repeat (SAT + 5) tick();
        #2;
        total++;
        if (StallCount !== 4'(SAT)) begin bad++; $display("FAIL stall_sat got=%0d exp=%0d", StallCount, SAT); end
        idle_inputs();
        PCSrcE = 2'b11;
        repeat (SAT + 5) tick();
        #2;
        total++;
        if (FlushCount !== 4'(SAT) || StallCount !== 4'(SAT)) begin
            bad++; $display("FAIL flush_sat fc=%0d sc=%0d exp=%0d", FlushCount, StallCount, SAT);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [10:0] e;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 59) == 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            MemReqM    = ($urandom_range(0, 2) == 0);
            MemAckM    = ($urandom_range(0, 3) == 0);
            #2;
            e = exp_comb();
            total++;
            if (obs !== e) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", c, obs, e); end
            total++;
            if (MemErr !== m_err || StallCount !== 4'(m_sc) || FlushCount !== 4'(m_fc)) begin
                bad++; $display("FAIL rand_regs cyc=%0d err=%b/%b sc=%0d/%0d fc=%0d/%0d", c, MemErr, m_err, StallCount, m_sc, FlushCount, m_fc);
            end
            tick();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_wait = 0; m_wcnt = 0; m_err = 0; m_sc = 0; m_fc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_rst_midwait();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
